// File: rtl/bombe_rotor_stepper.sv
// Odometer-style stepping controller for a three-rotor bombe stack: loads start positions,
// sweeps every rotor position, pauses on checker hits and mirrors the rotor positions.
module bombe_rotor_stepper #(
  parameter int unsigned ROTOR_SIZE    = 26,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  init_fast,
  input  logic [4:0]  init_mid,
  input  logic [4:0]  init_slow,
  input  logic        hit,
  input  logic        resume,
  output logic        load_rotors,
  output logic        step_fast,
  output logic        step_mid,
  output logic        step_slow,
  output logic [4:0]  pos_fast,
  output logic [4:0]  pos_mid,
  output logic [4:0]  pos_slow,
  output logic [14:0] step_count,
  output logic        busy,
  output logic        halted,
  output logic        done
);

  localparam int unsigned TOTAL_POS = ROTOR_SIZE * ROTOR_SIZE * ROTOR_SIZE;
  localparam int unsigned SettleW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [4:0]         PosMax     = 5'(ROTOR_SIZE - 1);
  localparam logic [14:0]        CountLast  = 15'(TOTAL_POS - 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StHalt, StDone} state_e;

  state_e              state_q, state_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic                load_q, load_d;
  logic                sf_q, sf_d, sm_q, sm_d, ss_q, ss_d;
  logic [4:0]          pf_q, pf_d, pm_q, pm_d, ps_q, ps_d;
  logic [14:0]         count_q, count_d;
  logic                do_step, do_load;

  // Out-of-range start positions are forced to 0 so the mirror never leaves 0..ROTOR_SIZE-1.
  function automatic logic [4:0] clamp_init(input logic [4:0] v);
    return (32'(v) >= ROTOR_SIZE) ? 5'd0 : v;
  endfunction

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    load_d   = 1'b0;
    sf_d     = 1'b0;
    sm_d     = 1'b0;
    ss_d     = 1'b0;
    pf_d     = pf_q;
    pm_d     = pm_q;
    ps_d     = ps_q;
    count_d  = count_q;
    do_step  = 1'b0;
    do_load  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) do_load = 1'b1;
      end
      StLoad: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          state_d  = StRun;
          settle_d = '0;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (hit) begin
          state_d = StHalt;
        end else if (settle_q == SettleLast) begin
          if (count_q == CountLast) begin
            state_d = StDone;
          end else begin
            do_step  = 1'b1;
            settle_d = '0;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StHalt: begin
        if (abort) begin
          state_d = StIdle;
        end else if (resume) begin
          if (count_q == CountLast) begin
            state_d = StDone;
          end else begin
            do_step  = 1'b1;
            state_d  = StRun;
            settle_d = '0;
          end
        end
      end
      StDone: begin
        if (abort) begin
          state_d = StIdle;
        end else if (start) begin
          do_load = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_load) begin
      state_d = StLoad;
      load_d  = 1'b1;
      pf_d    = clamp_init(init_fast);
      pm_d    = clamp_init(init_mid);
      ps_d    = clamp_init(init_slow);
      count_d = '0;
    end

    // Odometer carry chain: each wrap of a rotor pushes one step into the next.
    if (do_step) begin
      sf_d    = 1'b1;
      count_d = count_q + 15'd1;
      if (pf_q == PosMax) begin
        pf_d = '0;
        sm_d = 1'b1;
        if (pm_q == PosMax) begin
          pm_d = '0;
          ss_d = 1'b1;
          ps_d = (ps_q == PosMax) ? 5'd0 : ps_q + 5'd1;
        end else begin
          pm_d = pm_q + 5'd1;
        end
      end else begin
        pf_d = pf_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= StIdle;
      settle_q <= '0;
      load_q   <= 1'b0;
      sf_q     <= 1'b0;
      sm_q     <= 1'b0;
      ss_q     <= 1'b0;
      pf_q     <= '0;
      pm_q     <= '0;
      ps_q     <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      load_q   <= load_d;
      sf_q     <= sf_d;
      sm_q     <= sm_d;
      ss_q     <= ss_d;
      pf_q     <= pf_d;
      pm_q     <= pm_d;
      ps_q     <= ps_d;
      count_q  <= count_d;
    end
  end

  assign load_rotors = load_q;
  assign step_fast   = sf_q;
  assign step_mid    = sm_q;
  assign step_slow   = ss_q;
  assign pos_fast    = pf_q;
  assign pos_mid     = pm_q;
  assign pos_slow    = ps_q;
  assign step_count  = count_q;
  assign busy        = (state_q == StLoad) || (state_q == StRun) || (state_q == StHalt);
  assign halted      = (state_q == StHalt);
  assign done        = (state_q == StDone);

endmodule

// File: tb/tb_bombe_rotor_stepper.sv
// Self-checking bench for bombe_rotor_stepper: linear-index position model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_bombe_rotor_stepper;

  localparam int Rs     = 26;
  localparam int Settle = 2;
  localparam int Total  = Rs * Rs * Rs;

  localparam int MIdle = 0;
  localparam int MLoad = 1;
  localparam int MRun  = 2;
  localparam int MHalt = 3;
  localparam int MDone = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        hit = 1'b0;
  logic        resume = 1'b0;
  logic [4:0]  init_fast = '0;
  logic [4:0]  init_mid = '0;
  logic [4:0]  init_slow = '0;
  logic        load_rotors, step_fast, step_mid, step_slow;
  logic [4:0]  pos_fast, pos_mid, pos_slow;
  logic [14:0] step_count;
  logic        busy, halted, done;

  bombe_rotor_stepper #(
    .ROTOR_SIZE   (Rs),
    .SETTLE_CYCLES(Settle)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .init_fast  (init_fast),
    .init_mid   (init_mid),
    .init_slow  (init_slow),
    .hit        (hit),
    .resume     (resume),
    .load_rotors(load_rotors),
    .step_fast  (step_fast),
    .step_mid   (step_mid),
    .step_slow  (step_slow),
    .pos_fast   (pos_fast),
    .pos_mid    (pos_mid),
    .pos_slow   (pos_slow),
    .step_count (step_count),
    .busy       (busy),
    .halted     (halted),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: the rotor stack is one base-26 number m_idx = slow*676 + mid*26 + fast.
  int m_mode = MIdle;
  int m_settle = 0;
  int m_idx = 0;
  int m_count = 0;
  bit m_load = 0, m_sf = 0, m_sm = 0, m_ss = 0;

  function automatic int san(input logic [4:0] v);
    return (int'(v) >= Rs) ? 0 : int'(v);
  endfunction

  always @(posedge clk) begin
    bit go_step, go_load;
    go_step = 0;
    go_load = 0;
    if (!resetn) begin
      m_mode = MIdle; m_settle = 0; m_idx = 0; m_count = 0;
      m_load = 0; m_sf = 0; m_sm = 0; m_ss = 0;
    end else begin
      m_load = 0; m_sf = 0; m_sm = 0; m_ss = 0;
      if (m_mode != MIdle && abort) begin
        m_mode = MIdle;
      end else if (m_mode == MIdle || m_mode == MDone) begin
        if (start) go_load = 1;
      end else if (m_mode == MLoad) begin
        m_mode = MRun;
        m_settle = 0;
      end else if (m_mode == MRun) begin
        if (hit) m_mode = MHalt;
        else if (m_settle < Settle - 1) m_settle++;
        else if (m_count == Total - 1) m_mode = MDone;
        else begin go_step = 1; m_settle = 0; end
      end else if (m_mode == MHalt && resume) begin
        if (m_count == Total - 1) m_mode = MDone;
        else begin go_step = 1; m_mode = MRun; m_settle = 0; end
      end
      if (go_load) begin
        m_mode = MLoad; m_load = 1; m_count = 0;
        m_idx = san(init_slow) * Rs * Rs + san(init_mid) * Rs + san(init_fast);
      end
      if (go_step) begin
        m_idx = (m_idx + 1) % Total;
        m_count++;
        m_sf = 1;
        m_sm = (m_idx % Rs) == 0;
        m_ss = (m_idx % (Rs * Rs)) == 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [36:0] exp_v, act_v;
    if (chk_en) begin
      exp_v = {m_load, m_sf, m_sm, m_ss, 5'(m_idx % Rs), 5'((m_idx / Rs) % Rs),
               5'(m_idx / (Rs * Rs)), 15'(m_count),
               (m_mode == MLoad || m_mode == MRun || m_mode == MHalt),
               (m_mode == MHalt), (m_mode == MDone)};
      act_v = {load_rotors, step_fast, step_mid, step_slow, pos_fast, pos_mid, pos_slow,
               step_count, busy, halted, done};
      n_vec++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t got=%h want=%h", $time, act_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // which: 0 = step_count, 1 = pos_mid, 2 = done
  task automatic wait_sig(input int which, input int val, input int budget);
    bit hit_it;
    hit_it = 0;
    for (int i = 0; i < budget && !hit_it; i++) begin
      tick();
      if (which == 0 && int'(step_count) == val) hit_it = 1;
      if (which == 1 && int'(pos_mid) == val) hit_it = 1;
      if (which == 2 && int'(done) == val) hit_it = 1;
    end
    if (!hit_it) check("wait_timeout", 32'(which), 32'hFFFF);
  endtask

  initial begin
    tick();
    tick();
    chk_en = 1'b1;
    check("reset_busy", busy, 0);
    check("reset_pos", {pos_slow, pos_mid, pos_fast}, 0);
    check("reset_count", step_count, 0);
    resetn = 1'b1;
    tick();

    // Sweep from 0/0/0: load pulse, carry into middle rotor, hit at 40, resume.
    pulse_start();
    check("load_pulse", load_rotors, 1);
    tick();
    check("load_once", load_rotors, 0);
    wait_sig(1, 1, 200);
    check("carry_strobes", {step_fast, step_mid, step_slow}, 3'b110);
    check("carry_fast", pos_fast, 0);
    check("carry_count", step_count, 26);
    wait_sig(0, 40, 200);
    hit = 1'b1;
    tick();
    check("halt_enter", halted, 1);
    repeat (3) tick();
    hit = 1'b0;
    repeat (10) tick();
    check("halt_pos", {pos_slow, pos_mid, pos_fast}, {5'd0, 5'd1, 5'd14});
    check("halt_count", step_count, 40);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_strobe", {step_fast, step_mid, step_slow}, 3'b100);
    check("resume_count", step_count, 41);
    check("resume_run", {busy, halted}, 2'b10);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy_ignored", load_rotors, 0);
    // This abort lands on the final settle cycle, so it must suppress the step.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", busy, 0);
    check("abort_no_step", step_count, 41);

    // All three rotors wrap on the first step.
    init_fast = 5'd25; init_mid = 5'd25; init_slow = 5'd25;
    pulse_start();
    wait_sig(0, 1, 20);
    check("wrap_strobes", {step_fast, step_mid, step_slow}, 3'b111);
    check("wrap_pos", {pos_slow, pos_mid, pos_fast}, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Full sweep ends one position before the start.
    init_fast = 5'd3; init_mid = 5'd7; init_slow = 5'd11;
    pulse_start();
    wait_sig(2, 1, 40000);
    check("sweep_count", step_count, 17575);
    check("sweep_pos", {pos_slow, pos_mid, pos_fast}, {5'd11, 5'd7, 5'd2});
    check("sweep_no_strobe", {step_fast, step_mid, step_slow}, 0);
    check("sweep_busy", busy, 0);
    repeat (3) tick();
    check("done_hold", done, 1);

    // Out-of-range init from DONE, then abort out of HALT while hit is still high.
    init_fast = 5'd30; init_mid = 5'd26; init_slow = 5'd31;
    pulse_start();
    check("clamp_load", load_rotors, 1);
    check("clamp_pos", {pos_slow, pos_mid, pos_fast}, 0);
    wait_sig(0, 3, 20);
    hit = 1'b1;
    tick();
    check("halt2_enter", halted, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    hit = 1'b0;
    check("abort_halt_flags", {busy, halted, done}, 0);
    check("abort_halt_strobes", {load_rotors, step_fast, step_mid, step_slow}, 0);
    check("abort_halt_pos", pos_fast, 3);

    // Reset mid-run clears everything, with no strobe.
    init_fast = 5'd0; init_mid = 5'd0; init_slow = 5'd0;
    pulse_start();
    wait_sig(0, 2, 20);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("midrst_all", {load_rotors, step_fast, step_mid, step_slow, pos_fast, pos_mid,
                         pos_slow, step_count, busy, halted, done}, 0);
    repeat (3) tick();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
